// File: rtl/output_pixel_buffer.sv
// rtl/output_pixel_buffer.sv - byte-wide multi-lane frame store drained as BPW-byte words over valid/ready
//
// Purpose: collects up to CHANNELS pixel bytes per cycle into a DEPTH-byte frame
// store while filling, then on I_OBUF_FRAME_DONE streams the whole store out as
// little-endian BPW-byte words toward the AHB master write path.
//
// Ports:
//   I_OBUF_HCLK        clock
//   I_OBUF_HRESET      synchronous active-high reset
//   I_OBUF_WRITE       pixel write strobe (all lanes together)
//   I_OBUF_PIXEL       lane n byte at [8n+7:8n]
//   I_OBUF_ADDR        lane n byte address at [AW*n+AW-1:AW*n]
//   I_OBUF_FRAME_DONE  pulse that starts the drain
//   I_OBUF_WREADY      downstream accepts the current word
//   O_OBUF_WDATA       word; byte k = mem[word*BPW+k]
//   O_OBUF_WADDR       index of the word on O_OBUF_WDATA
//   O_OBUF_WVALID      word valid
//   O_OBUF_BUSY        high while draining
//   O_OBUF_DONE        one-cycle pulse after the last word is accepted
//   O_OBUF_ERR         sticky error flag, cleared only by reset
module output_pixel_buffer #(
    parameter int CHANNELS = 3,
    parameter int BPW      = 4,
    parameter int DEPTH    = 192,
    parameter int AW       = 8,
    parameter int WAW      = 6
) (
    input  logic                  I_OBUF_HCLK,
    input  logic                  I_OBUF_HRESET,
    input  logic                  I_OBUF_WRITE,
    input  logic [CHANNELS*8-1:0] I_OBUF_PIXEL,
    input  logic [CHANNELS*AW-1:0] I_OBUF_ADDR,
    input  logic                  I_OBUF_FRAME_DONE,
    input  logic                  I_OBUF_WREADY,
    output logic [BPW*8-1:0]      O_OBUF_WDATA,
    output logic [WAW-1:0]        O_OBUF_WADDR,
    output logic                  O_OBUF_WVALID,
    output logic                  O_OBUF_BUSY,
    output logic                  O_OBUF_DONE,
    output logic                  O_OBUF_ERR
);

    localparam int NW = DEPTH / BPW;

    typedef enum logic {S_FILL = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [7:0]          r_mem [DEPTH];

    logic [BPW*8-1:0]    r_wdata;
    logic [WAW-1:0]      r_waddr;
    logic                r_wvalid;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [BPW*8-1:0]    w_wdata_nxt;
    logic [WAW-1:0]      w_waddr_nxt;
    logic                w_wvalid_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;

    logic [AW-1:0]       w_lane_addr [CHANNELS];
    logic [7:0]          w_lane_pix  [CHANNELS];
    logic [CHANNELS-1:0] w_lane_bad;
    logic [CHANNELS-1:0] w_wr_en;

    logic                w_fill;
    logic                w_xfer;
    logic                w_last;
    logic [WAW-1:0]      w_rd_idx;
    logic [BPW*8-1:0]    w_rd_word;
    int                  w_rd_byte_addr;
    logic [7:0]          w_rd_byte;

    assign w_fill = (r_state == S_FILL);
    assign w_xfer = r_wvalid & I_OBUF_WREADY;
    assign w_last = (r_waddr == WAW'(NW - 1));

    // Lane unpacking and per-lane write qualification.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            w_lane_addr[n] = I_OBUF_ADDR[AW*n +: AW];
            w_lane_pix[n]  = I_OBUF_PIXEL[8*n +: 8];
            w_lane_bad[n]  = (int'(w_lane_addr[n]) >= DEPTH);
            w_wr_en[n]     = w_fill & I_OBUF_WRITE & ~w_lane_bad[n];
        end
    end

    // Word fetch for the next O_OBUF_WDATA. While filling the only word ever
    // loaded is word 0, and a write on the same edge must show up in it, so
    // pending lane writes are overlaid in lane order (highest lane wins).
    always_comb begin
        w_rd_idx       = w_fill ? '0 : (r_waddr + WAW'(1));
        w_rd_word      = '0;
        w_rd_byte_addr = 0;
        w_rd_byte      = '0;
        for (int k = 0; k < BPW; k++) begin
            w_rd_byte_addr = int'(w_rd_idx) * BPW + k;
            w_rd_byte      = '0;
            if (w_rd_byte_addr < DEPTH) begin
                w_rd_byte = r_mem[w_rd_byte_addr[AW-1:0]];
            end
            for (int n = 0; n < CHANNELS; n++) begin
                if (w_wr_en[n] && (int'(w_lane_addr[n]) == w_rd_byte_addr)) begin
                    w_rd_byte = w_lane_pix[n];
                end
            end
            w_rd_word[8*k +: 8] = w_rd_byte;
        end
    end

    // FSM: state register.
    always_ff @(posedge I_OBUF_HCLK) begin
        if (I_OBUF_HRESET) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (I_OBUF_FRAME_DONE)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_xfer && w_last)   w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // FSM: output logic (next values of the registered outputs).
    always_comb begin
        w_wdata_nxt  = r_wdata;
        w_waddr_nxt  = r_waddr;
        w_wvalid_nxt = r_wvalid;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;
        case (r_state)
            S_FILL: begin
                if (I_OBUF_WRITE && (|w_lane_bad)) begin
                    w_err_nxt = 1'b1;
                end
                if (I_OBUF_FRAME_DONE) begin
                    w_waddr_nxt  = '0;
                    w_wdata_nxt  = w_rd_word;
                    w_wvalid_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (I_OBUF_WRITE || I_OBUF_FRAME_DONE) begin
                    w_err_nxt = 1'b1;
                end
                if (w_xfer) begin
                    if (w_last) begin
                        w_wvalid_nxt = 1'b0;
                        w_busy_nxt   = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_waddr_nxt  = '0;
                    end else begin
                        w_waddr_nxt  = r_waddr + WAW'(1);
                        w_wdata_nxt  = w_rd_word;
                    end
                end
            end
            default: begin
                w_wvalid_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    // Output registers and frame store.
    always_ff @(posedge I_OBUF_HCLK) begin
        if (I_OBUF_HRESET) begin
            r_wdata  <= '0;
            r_waddr  <= '0;
            r_wvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_wdata  <= w_wdata_nxt;
            r_waddr  <= w_waddr_nxt;
            r_wvalid <= w_wvalid_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            // Later lanes overwrite earlier ones on a shared address.
            for (int n = 0; n < CHANNELS; n++) begin
                if (w_wr_en[n]) begin
                    r_mem[w_lane_addr[n]] <= w_lane_pix[n];
                end
            end
        end
    end

    assign O_OBUF_WDATA  = r_wdata;
    assign O_OBUF_WADDR  = r_waddr;
    assign O_OBUF_WVALID = r_wvalid;
    assign O_OBUF_BUSY   = r_busy;
    assign O_OBUF_DONE   = r_done;
    assign O_OBUF_ERR    = r_err;

endmodule

// File: tb/tb_output_pixel_buffer.sv
// tb/tb_output_pixel_buffer.sv - self-checking bench for output_pixel_buffer
module tb_output_pixel_buffer;

    logic        clk;
    logic        hreset;
    logic        wr;
    logic [23:0] pixel;
    logic [23:0] addr;
    logic        frame_done;
    logic        wready;
    logic [31:0] wdata;
    logic [5:0]  waddr;
    logic        wvalid;
    logic        busy;
    logic        done;
    logic        err;

    output_pixel_buffer #(
        .CHANNELS(3), .BPW(4), .DEPTH(192), .AW(8), .WAW(6)
    ) dut (
        .I_OBUF_HCLK      (clk),
        .I_OBUF_HRESET    (hreset),
        .I_OBUF_WRITE     (wr),
        .I_OBUF_PIXEL     (pixel),
        .I_OBUF_ADDR      (addr),
        .I_OBUF_FRAME_DONE(frame_done),
        .I_OBUF_WREADY    (wready),
        .O_OBUF_WDATA     (wdata),
        .O_OBUF_WADDR     (waddr),
        .O_OBUF_WVALID    (wvalid),
        .O_OBUF_BUSY      (busy),
        .O_OBUF_DONE      (done),
        .O_OBUF_ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    int n_done  = 0;

    // Reference model: byte array plus a "which word is being offered" view.
    logic [7:0] m_mem [192];
    logic       m_drain;
    int         m_widx;
    logic       m_done;
    logic       m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input int idx);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = m_mem[idx*4 + k];
        return w;
    endfunction

    task automatic model_step(input logic i_wr, input logic [23:0] i_pix, input logic [23:0] i_adr,
                              input logic i_fd, input logic i_rdy, input logic i_rst);
        int a;
        if (i_rst) begin
            for (int i = 0; i < 192; i++) m_mem[i] = 8'h00;
            m_drain = 1'b0; m_widx = 0; m_done = 1'b0; m_err = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (!m_drain) begin
            if (i_wr) begin
                for (int n = 0; n < 3; n++) begin
                    a = int'(i_adr[8*n +: 8]);
                    if (a < 192) m_mem[a] = i_pix[8*n +: 8];
                    else m_err = 1'b1;
                end
            end
            if (i_fd) begin
                m_drain = 1'b1;
                m_widx  = 0;
            end
        end else begin
            if (i_wr || i_fd) m_err = 1'b1;
            if (i_rdy) begin
                if (m_widx == 47) begin
                    m_drain = 1'b0; m_done = 1'b1; m_widx = 0;
                end else begin
                    m_widx++;
                end
            end
        end
    endtask

    // One clock: apply inputs, step the model at the edge, compare #1 later.
    task automatic cycle(input logic i_wr, input logic [23:0] i_pix, input logic [23:0] i_adr,
                         input logic i_fd, input logic i_rdy, input logic i_rst);
        logic        pv;
        logic [31:0] pd;
        logic [5:0]  pa;
        wr = i_wr; pixel = i_pix; addr = i_adr; frame_done = i_fd; wready = i_rdy; hreset = i_rst;
        pv = wvalid; pd = wdata; pa = waddr;
        if (wvalid && i_rdy && !i_rst) n_xfer++;
        @(posedge clk);
        model_step(i_wr, i_pix, i_adr, i_fd, i_rdy, i_rst);
        #1;
        if (done) n_done++;
        check("wvalid", {31'b0, wvalid}, {31'b0, m_drain});
        check("busy",   {31'b0, busy},   {31'b0, m_drain});
        check("done",   {31'b0, done},   {31'b0, m_done});
        check("err",    {31'b0, err},    {31'b0, m_err});
        check("waddr",  {26'b0, waddr},  32'(m_widx));
        if (m_drain) check("wdata", wdata, m_word(m_widx));
        if (pv && !i_rdy && !i_rst) begin
            check("hold_data", wdata, pd);
            check("hold_addr", {26'b0, waddr}, {26'b0, pa});
        end
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 24'h0, 24'h0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_drain();
        int guard = 0;
        while (!done && guard < 200) begin
            idle(1'b1);
            guard++;
        end
        if (guard >= 200) check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [23:0] ra;
        hreset = 1'b0; wr = 1'b0; pixel = '0; addr = '0; frame_done = 1'b0; wready = 1'b0;
        @(negedge clk);

        // Reset values.
        do_reset();
        check("rst_wdata", wdata, 32'h0);
        check("rst_err", {31'b0, err}, 32'd0);

        // Empty frame: 48 zero words back to back, one DONE.
        n_xfer = 0; n_done = 0;
        cycle(1'b0, 24'h0, 24'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 48; i++) begin
            check("t1_zero", wdata, 32'h0);
            idle(1'b1);
        end
        check("t1_done_now", {31'b0, done}, 32'd1);
        idle(1'b1);
        check("t1_xfers", 32'(n_xfer), 32'd48);
        check("t1_done_cnt", 32'(n_done), 32'd1);
        check("t1_err", {31'b0, err}, 32'd0);

        // Lane packing into word 0, one-cycle latency.
        cycle(1'b1, {8'h33, 8'h22, 8'h11}, {8'd2, 8'd1, 8'd0}, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, {8'h44, 8'h44, 8'h44}, {8'd3, 8'd3, 8'd3}, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b0);
        check("t2_valid", {31'b0, wvalid}, 32'd1);
        check("t2_word0", wdata, 32'h44332211);
        run_drain();

        // Collision: highest lane wins.
        cycle(1'b1, {8'hCC, 8'hBB, 8'hAA}, {8'd5, 8'd5, 8'd5}, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 24'h0, 24'h0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("t3_word1", wdata, 32'h0000CC00);
        run_drain();

        // Forwarding of a write coincident with FRAME_DONE.
        do_reset();
        cycle(1'b1, {8'h5A, 8'h5A, 8'h5A}, {8'd7, 8'd7, 8'd7}, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("t4_word1", wdata, 32'h5A000000);
        run_drain();

        // Backpressure 1,0,0,1 pattern.
        n_xfer = 0; n_done = 0;
        cycle(1'b0, 24'h0, 24'h0, 1'b1, 1'b1, 1'b0);
        guard = 0;
        while (!done && guard < 400) begin
            idle((guard % 4 == 0) || (guard % 4 == 3));
            guard++;
        end
        check("t5_xfers", 32'(n_xfer), 32'd48);
        check("t5_done_cnt", 32'(n_done), 32'd1);

        // Back-to-back frame: FRAME_DONE while DONE is high.
        cycle(1'b0, 24'h0, 24'h0, 1'b1, 1'b1, 1'b0);
        check("t5_b2b_busy", {31'b0, busy}, 32'd1);
        check("t5_b2b_err", {31'b0, err}, 32'd0);
        run_drain();

        // Errors: out-of-range lane, write during drain, reset mid-drain.
        cycle(1'b1, {8'h77, 8'h66, 8'h55}, {8'd200, 8'd11, 8'd10}, 1'b0, 1'b1, 1'b0);
        check("t6_err_range", {31'b0, err}, 32'd1);
        do_reset();
        check("t6_err_clr", {31'b0, err}, 32'd0);
        cycle(1'b1, 24'hABCDEF, {8'd0, 8'd1, 8'd2}, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 24'h0, 24'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 24'h123456, {8'd4, 8'd5, 8'd6}, 1'b0, 1'b1, 1'b0);
        check("t6_err_drainwr", {31'b0, err}, 32'd1);
        guard = 0;
        while (waddr != 6'd20 && guard < 100) begin
            idle(1'b1);
            guard++;
        end
        if (guard >= 100) check("t6_seek_timeout", 32'd1, 32'd0);
        cycle(1'b0, 24'h0, 24'h0, 1'b0, 1'b1, 1'b1);
        check("t6_rst_valid", {31'b0, wvalid}, 32'd0);
        check("t6_rst_err", {31'b0, err}, 32'd0);
        check("t6_rst_done", {31'b0, done}, 32'd0);
        cycle(1'b0, 24'h0, 24'h0, 1'b1, 1'b1, 1'b0);
        guard = 0;
        while (!done && guard < 200) begin
            if (wvalid) check("t6_zero", wdata, 32'h0);
            idle(1'b1);
            guard++;
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 3; n++)
                ra[8*n +: 8] = ($urandom % 8 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 191));
            cycle(($urandom % 4) == 0,
                  24'($urandom),
                  ra,
                  busy ? (($urandom % 60) == 0) : (done ? (($urandom % 2) == 0) : (($urandom % 30) == 0)),
                  ($urandom % 4) != 0,
                  ($urandom % 1500) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
